// File: rtl/testmult_pkg.sv
// -----------------------------------------------------------------------------
// testmult_pkg
// Shared types, default widths and the residue helper for the pipelined
// multiply / multiply-accumulate test engine (testmult_pipe).
//
// Optional feature: `TESTMULT_RESIDUE_CHECK_EN adds a residue field to the
// pipeline stage record. Without the macro the field does not exist.
// -----------------------------------------------------------------------------
package testmult_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int IN_W_DEF   = 32;
  localparam int STAGES_DEF = 3;
  localparam int ACC_W_DEF  = 44;
  localparam int RES_W_DEF  = 4;

  // Upper bounds for the stage record fields. The record is shared by all
  // parameterisations, so it is sized for the widest legal product/residue.
  localparam int MAX_PROD_W = 64;
  localparam int MAX_RES_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,   // no operands held
    ST_ARMED,  // operands held, engine stalled
    ST_RUN     // operands held, issuing every enabled cycle
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [MAX_PROD_W-1:0] prod;
`ifdef TESTMULT_RESIDUE_CHECK_EN
    logic [MAX_RES_W-1:0]  res;
`endif
  } stage_t;

  // Residue of x modulo 2^w - 1. Bit i carries weight 2^(i mod w); the
  // weighted sum is then end-around folded. The all-ones code is the second
  // representation of zero and is canonicalised to 0. Valid for 2 <= w <= 16.
  function automatic logic [MAX_RES_W-1:0] mod_mersenne(input logic [MAX_PROD_W-1:0] x,
                                                        input int w);
    logic [31:0] s;
    logic [31:0] m;
    s = '0;
    m = (32'd1 << w) - 32'd1;
    for (int i = 0; i < MAX_PROD_W; i++) begin
      if (x[i]) s = s + (32'd1 << (i % w));
    end
    for (int k = 0; k < 8; k++) begin
      s = (s & m) + (s >> w);
    end
    if (s == m) s = '0;
    return s[MAX_RES_W-1:0];
  endfunction

endpackage

// File: rtl/testmult_pipe_if.sv
// -----------------------------------------------------------------------------
// testmult_pipe_if
// Load/control and result bus of the test multiplier.
//   master : control side (drives run/load/mode controls, reads results)
//   slave  : the engine itself
// Signals: clk_ena, load_ena, load_data1/2, mode, acc_clr, fault_inj (in to
// engine); data_out, out_valid, out_cnt, acc_ovf, res_err (out of engine).
// -----------------------------------------------------------------------------
interface testmult_pipe_if #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 44
);
  logic             clk_ena;
  logic             load_ena;
  logic [IN_W-1:0]  load_data1;
  logic [IN_W-1:0]  load_data2;
  logic             mode;
  logic             acc_clr;
  logic             fault_inj;
  logic [ACC_W-1:0] data_out;
  logic             out_valid;
  logic [15:0]      out_cnt;
  logic             acc_ovf;
  logic             res_err;

  modport master (
    output clk_ena, load_ena, load_data1, load_data2, mode, acc_clr, fault_inj,
    input  data_out, out_valid, out_cnt, acc_ovf, res_err
  );

  modport slave (
    input  clk_ena, load_ena, load_data1, load_data2, mode, acc_clr, fault_inj,
    output data_out, out_valid, out_cnt, acc_ovf, res_err
  );
endinterface

// File: rtl/residue_mod.sv
// -----------------------------------------------------------------------------
// residue_mod
// Registered residue folder: captures (data mod 2^RES_W - 1) whenever
// load_ena is high, so the residue is available in the same cycle as the
// operand register it shadows. Used only by residue-checking builds.
// Ports: clk, rst_n, load_ena, data [DATA_W], res [RES_W].
// -----------------------------------------------------------------------------
module residue_mod
  import testmult_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int RES_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_ena,
  input  logic [DATA_W-1:0] data,
  output logic [RES_W-1:0]  res
);
  logic [RES_W-1:0] res_q, res_d;

  always_comb begin
    res_d = res_q;
    if (load_ena) res_d = RES_W'(mod_mersenne(MAX_PROD_W'(data), RES_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= '0;
    else        res_q <= res_d;
  end

  assign res = res_q;
endmodule

// File: rtl/testmult_pipe.sv
// -----------------------------------------------------------------------------
// testmult_pipe
// Pipelined multiply / multiply-accumulate test engine. Operands captured on
// load_ena are re-issued every cycle the FSM is in RUN; each product walks
// STAGES registers and is then either presented raw (mode 0) or folded into
// the ACC_W accumulator (mode 1). clk_ena low freezes every stage and the
// output/accumulator state.
// Ports: clk, rst_n (async, active low), bus (testmult_pipe_if.slave).
// Optional: `TESTMULT_RESIDUE_CHECK_EN adds a mod 2^RES_W-1 residue checker
// driving res_err and honouring fault_inj; otherwise res_err is tied low and
// fault_inj is ignored.
// -----------------------------------------------------------------------------
module testmult_pipe
  import testmult_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int RES_W  = RES_W_DEF
) (
  input logic             clk,
  input logic             rst_n,
  testmult_pipe_if.slave  bus
);

  if (DATA_W > IN_W || 2 * DATA_W > ACC_W || 2 * DATA_W > MAX_PROD_W ||
      STAGES < 1 || RES_W < 2 || RES_W > MAX_RES_W) begin : g_bad_cfg
    $error("testmult_pipe: illegal parameter combination");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  stage_t            out_st;
  logic [ACC_W-1:0]  acc_q, acc_d, data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d, acc_ovf_q, acc_ovf_d;
  logic [15:0]       out_cnt_q, out_cnt_d;
  logic              issue;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W:0]    sum;

`ifdef TESTMULT_RESIDUE_CHECK_EN
  logic [RES_W-1:0]  res_a, res_b;
  logic              res_err_q, res_err_d;

  residue_mod #(.DATA_W(DATA_W), .RES_W(RES_W)) u_res_a (
    .clk(clk), .rst_n(rst_n), .load_ena(bus.load_ena),
    .data(DATA_W'(bus.load_data1)), .res(res_a)
  );
  residue_mod #(.DATA_W(DATA_W), .RES_W(RES_W)) u_res_b (
    .clk(clk), .rst_n(rst_n), .load_ena(bus.load_ena),
    .data(DATA_W'(bus.load_data2)), .res(res_b)
  );
`endif

  // The IDLE/ARMED -> RUN edge issues nothing; RUN with clk_ena low is a stall.
  assign issue = (state_q == ST_RUN) && bus.clk_ena;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:            if (bus.load_ena) state_d = ST_ARMED;
      ST_ARMED, ST_RUN:   state_d = bus.clk_ena ? ST_RUN : ST_ARMED;
      default:            state_d = ST_IDLE;
    endcase
  end

  // Loads are independent of clk_ena; an issue in the load cycle still sees
  // the old operands because it reads op_*_q.
  always_comb begin
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    if (bus.load_ena) begin
      op_a_d = DATA_W'(bus.load_data1);
      op_b_d = DATA_W'(bus.load_data2);
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) st_d[i] = st_q[i];
    if (bus.clk_ena) begin
      st_d[0]       = '0;
      st_d[0].valid = issue;
      if (issue) begin
        st_d[0].prod = MAX_PROD_W'(op_a_q) * MAX_PROD_W'(op_b_q);
`ifdef TESTMULT_RESIDUE_CHECK_EN
        st_d[0].prod[0] = st_d[0].prod[0] ^ bus.fault_inj;
        st_d[0].res     = mod_mersenne(MAX_PROD_W'(res_a) * MAX_PROD_W'(res_b), RES_W);
`endif
      end
      for (int i = 1; i < STAGES; i++) st_d[i] = st_q[i-1];
    end
  end

  assign out_st = st_q[STAGES-1];

  always_comb begin
    prod_ext    = ACC_W'(out_st.prod);
    sum         = {1'b0, acc_q} + {1'b0, prod_ext};
    out_valid_d = bus.clk_ena && out_st.valid;
    data_out_d  = data_out_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    out_cnt_d   = out_cnt_q;
    if (out_valid_d) begin
      out_cnt_d = out_cnt_q + 16'd1;
      if (bus.acc_clr) begin
        acc_d     = prod_ext;
        acc_ovf_d = 1'b0;
      end else if (bus.mode) begin
        acc_d = sum[ACC_W-1:0];
        if (sum[ACC_W]) acc_ovf_d = 1'b1;
      end
      data_out_d = bus.mode ? acc_d : prod_ext;
    end else if (bus.clk_ena && bus.acc_clr) begin
      acc_d     = '0;
      acc_ovf_d = 1'b0;
    end
  end

`ifdef TESTMULT_RESIDUE_CHECK_EN
  // Compared against the residue of the product as it actually left the
  // pipeline, so a corrupted product is caught even though its operands were fine.
  always_comb begin
    res_err_d = 1'b0;
    if (out_valid_d) res_err_d = (mod_mersenne(out_st.prod, RES_W) != out_st.res);
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  // NOTE: every stage (not just its valid bit) is reset, so a reset mid-run
  // flushes in-flight results and the output values start from a known 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      for (int i = 0; i < STAGES; i++) st_q[i] <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      acc_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
`ifdef TESTMULT_RESIDUE_CHECK_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      for (int i = 0; i < STAGES; i++) st_q[i] <= st_d[i];
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      acc_ovf_q   <= acc_ovf_d;
      out_cnt_q   <= out_cnt_d;
`ifdef TESTMULT_RESIDUE_CHECK_EN
      res_err_q   <= res_err_d;
`endif
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.acc_ovf   = acc_ovf_q;
`ifdef TESTMULT_RESIDUE_CHECK_EN
  assign bus.res_err   = res_err_q;
`else
  assign bus.res_err   = 1'b0;
`endif

endmodule

// File: doc/testmult_pipe.md
# testmult_pipe

Parametrised, pipelined multiply / multiply-accumulate test engine, the next generation of the fixed 18x18 test multiplier. Operands are loaded from 32-bit buses and repeatedly issued into a STAGES-deep pipeline while `clk_ena` is high. Results can stream as raw products or fold into a wide accumulator. It sits behind the FPGA demo's load/control registers and feeds the result-check logic. An optional residue checker flags arithmetic faults per result.

## Interface
- `DATA_W`, 18: operand width; operands are the low `DATA_W` bits of the load buses (`DATA_W` ≤ `IN_W`).
- `IN_W`, 32: load bus width.
- `STAGES`, 3: pipeline depth from issue to result, ≥ 1.
- `ACC_W`, 44: result/accumulator width, ≥ 2·`DATA_W`.
- `RES_W`, 4: residue modulus is 2^`RES_W` − 1 (used only with the checker).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `clk_ena` in 1: run/stall; low freezes the whole pipeline.
- `load_ena` in 1: capture operands.
- `load_data1` in `IN_W`: operand A source.
- `load_data2` in `IN_W`: operand B source.
- `mode` in 1: 0 = multiply, 1 = multiply-accumulate.
- `acc_clr` in 1: accumulator clear/restart.
- `fault_inj` in 1: checker builds only; flips product bit 0 at stage 1.
- `data_out` out `ACC_W`: product (zero-extended) or accumulator.
- `out_valid` out 1: `data_out` updated this cycle.
- `out_cnt` out 16: results produced since reset, wraps.
- `acc_ovf` out 1: sticky accumulator carry-out.
- `res_err` out 1: checker builds only; residue mismatch, qualified by `out_valid`.

## Operation
- FSM states:
  - IDLE: no operands held.
  - ARMED: operands held, `clk_ena` low.
  - RUN: operands held, `clk_ena` high.
- FSM transitions:
  - IDLE→ARMED on `load_ena`.
  - ARMED↔RUN follows `clk_ena`.
  - Only reset returns to IDLE.
- `load_ena` captures `op_a`/`op_b` at any time, regardless of `clk_ena`. Operands are sticky until the next load.
- Issue: one product enters stage 1 on every cycle where the FSM is in RUN. A stream of identical products results until reload.
- Load and issue in the same cycle: the issue uses the old operands; new operands take effect at the next issue. The IDLE/ARMED→RUN edge issues nothing on that cycle.
- Mode 0: `data_out` = zero-extended product on each valid result.
- Mode 1 accumulator update, on each valid result:
  - acc ← acc + product, modulo 2^`ACC_W`.
  - Carry-out sets `acc_ovf`.
  - `data_out` = new acc.
- `acc_clr`:
  - With a valid result: acc ← product and `acc_ovf` is cleared.
  - Without a valid result: acc ← 0 and `acc_ovf` is cleared.
- `mode` is sampled per result at the output stage. Changing it mid-stream is legal and takes effect at the next result.
- Reset mid-run flushes all stages. In-flight results are discarded and are not counted.

## Timing
- Latency: a product issued at edge N appears with `out_valid`=1 at edge N+`STAGES`, given `clk_ena` high throughout. Each cycle with `clk_ena` low adds one cycle.
- Throughput: one result per enabled cycle.
- `clk_ena` low:
  - No stage advances.
  - `out_valid` = 0.
  - `data_out`, `acc`, `out_cnt` hold.
- Reset values: `data_out` 0, `out_valid` 0, `out_cnt` 0, `acc_ovf` 0, `res_err` 0, acc 0, operands 0, all stage-valid bits 0, FSM IDLE.
- `out_cnt` increments on each `out_valid` and wraps 0xFFFF→0.

## Configuration
- `TESTMULT_RESIDUE_CHECK_EN` defined:
  - Operand residues mod 2^`RES_W` − 1 are computed at load.
  - Their modular product travels alongside the pipeline.
  - At the output, it is compared with the residue of the raw product. `res_err` = mismatch on valid cycles and 0 otherwise.
  - `fault_inj` is honoured.
- Undefined: the checker logic is absent. The `fault_inj` input is still present and ignored, and `res_err` is tied to 0.

## Structure
- Package `testmult_pkg`:
  - FSM state enum.
  - Stage record typedef (valid, product, residue).
  - Default width constants.
  - `mod_mersenne` residue function.
- One sub-module, `residue_mod`: combinational-free registered residue folder, instantiated only under the macro.

## Test plan
- Multiply:
  - Stimulus: load 0x1234/0x5678, then `clk_ena`=1, mode 0.
  - Response: first `out_valid` `STAGES` cycles after the first issue; `data_out`=0x6260060 every cycle thereafter.
- Max operands:
  - Stimulus: 0x3FFFF × 0x3FFFF.
  - Response: `data_out`=0xFFFF80001.
- Accumulate:
  - Stimulus: mode 1, `acc_clr` on the first result.
  - Response: after 3 results `data_out`=0x12720120 and `out_cnt` advanced by 3.
- Stall:
  - Stimulus: drop `clk_ena` for 5 cycles mid-stream.
  - Response: `out_valid`=0 and outputs hold; the stream resumes with no lost or duplicated result. Total count is unchanged versus the unstalled run, plus 5 cycles.
- Reload and reset:
  - Stimulus: reload to 2×3 while running.
  - Response: 0x6260060 drains, then 6 appears.
  - Stimulus: assert `rst_n`=0 mid-stream.
  - Response: all outputs go to 0 immediately.
- Checker build:
  - Stimulus: pulse `fault_inj` for one issue.
  - Response: exactly one result = 0x6260061 with `res_err`=1; all other results show `res_err`=0.
